alu_seq: RTL

- Next-generation ALU for the simple processor datapath; replaces the purely combinational 8-bit ALU.
- Width is parameterised and the output is registered.
- Adds SUB, a multi-cycle MUL and a multi-cycle rotate, plus status flags (ZERO, CARRY, ERROR).
- Uses a START/BUSY/DONE handshake so the control unit can stall on multi-cycle ops.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_shift_add_mul.sv | 55 +++++
 rtl/alu_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_FWD  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per step.
module alu_shift_add_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;

  // Accumulator value after the current step; the full product on the last step.
  always_comb begin
    product = acc_r;
    if (mplier_r[0]) begin
      product = acc_r + mcand_r;
    end else begin
      product = acc_r;
    end
    done = step & (cnt_r == CW'(1));
  end

  // Operand load and per-step shift of multiplicand/multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (load) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
      cnt_r    <= CW'(WIDTH);
    end else if (step) begin
      acc_r    <= product;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with registered result/flags and START/BUSY/DONE handshake;
// MUL and non-zero ROR run multi-cycle, everything else completes at capture.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       ALUOP,
  input  logic [WIDTH-1:0] OPERAND1,
  input  logic [WIDTH-1:0] OPERAND2,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ZERO,
  output logic             CARRY,
  output logic             ERROR
);

  localparam int CW = SHW + 1;

  state_t             state_r, state_nxt_s;
  logic [2:0]         op_r, op_nxt_s;
  logic [CW-1:0]      cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0]   rot_r, rot_nxt_s;
  logic [WIDTH-1:0]   result_r, result_nxt_s;
  logic               zero_r, zero_nxt_s, carry_r, carry_nxt_s;
  logic               error_r, error_nxt_s, done_r, done_nxt_s, busy_r;
  logic [SHW-1:0]     amt_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   sc_res_s, comp_res_s;
  logic               sc_carry_s, sc_err_s, comp_carry_s, comp_err_s, complete_s;
  logic               mul_load_s, mul_step_s, mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;

  assign amt_s      = OPERAND1[SHW-1:0];
  assign mul_load_s = (state_r == ST_IDLE) & START & (ALUOP == OP_MUL);
  assign mul_step_s = (state_r == ST_EXEC) & (op_r == OP_MUL);

  alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (CLK),
    .rst_n   (RESET),
    .load    (mul_load_s),
    .step    (mul_step_s),
    .a       (OPERAND1),
    .b       (OPERAND2),
    .product (mul_prod_s),
    .done    (mul_done_s)
  );

  // Single-cycle datapath on the live inputs, used only at the capture edge.
  always_comb begin
    sum_s      = {1'b0, OPERAND1} + {1'b0, OPERAND2};
    sc_res_s   = OPERAND2;
    sc_carry_s = 1'b0;
    sc_err_s   = 1'b0;
    case (ALUOP)
      OP_FWD:  sc_res_s = OPERAND2;
      OP_ADD:  begin sc_res_s = sum_s[WIDTH-1:0]; sc_carry_s = sum_s[WIDTH]; end
      OP_AND:  sc_res_s = OPERAND1 & OPERAND2;
      OP_OR:   sc_res_s = OPERAND1 | OPERAND2;
      OP_SUB:  begin sc_res_s = OPERAND1 - OPERAND2; sc_carry_s = (OPERAND1 >= OPERAND2); end
      OP_RSVD: begin sc_res_s = {WIDTH{1'b0}}; sc_err_s = 1'b1; end
      default: sc_res_s = OPERAND2;  // ROR by zero; MUL never completes here
    endcase
  end

  // Next-state and completion logic; holds all state unless something completes.
  always_comb begin
    state_nxt_s  = state_r;
    op_nxt_s     = op_r;
    cnt_nxt_s    = cnt_r;
    rot_nxt_s    = rot_r;
    complete_s   = 1'b0;
    comp_res_s   = sc_res_s;
    comp_carry_s = sc_carry_s;
    comp_err_s   = sc_err_s;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          op_nxt_s  = ALUOP;
          rot_nxt_s = OPERAND2;
          if (ALUOP == OP_MUL) begin
            state_nxt_s = ST_EXEC;
            cnt_nxt_s   = CW'(WIDTH);
          end else if ((ALUOP == OP_ROR) && (amt_s != {SHW{1'b0}})) begin
            state_nxt_s = ST_EXEC;
            cnt_nxt_s   = {1'b0, amt_s};
          end else begin
            complete_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rot_nxt_s = {rot_r[0], rot_r[WIDTH-1:1]};
        cnt_nxt_s = cnt_r - CW'(1);
        if (op_r == OP_MUL) begin
          complete_s   = mul_done_s;
          comp_res_s   = mul_prod_s[WIDTH-1:0];
          comp_carry_s = |mul_prod_s[2*WIDTH-1:WIDTH];
        end else begin
          complete_s   = (cnt_r == CW'(1));
          comp_res_s   = {rot_r[0], rot_r[WIDTH-1:1]};
          comp_carry_s = 1'b0;
        end
        comp_err_s = 1'b0;
        if (complete_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    if (complete_s) begin
      result_nxt_s = comp_res_s;
      zero_nxt_s   = (comp_res_s == {WIDTH{1'b0}});
      carry_nxt_s  = comp_carry_s;
      error_nxt_s  = comp_err_s;
      done_nxt_s   = 1'b1;
    end else begin
      result_nxt_s = result_r;
      zero_nxt_s   = zero_r;
      carry_nxt_s  = carry_r;
      error_nxt_s  = error_r;
      done_nxt_s   = 1'b0;
    end
  end

  // State, datapath and output registers; reset aborts any op without DONE.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r  <= ST_IDLE;
      op_r     <= 3'b000;
      cnt_r    <= {CW{1'b0}};
      rot_r    <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      zero_r   <= 1'b0;
      carry_r  <= 1'b0;
      error_r  <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      op_r     <= op_nxt_s;
      cnt_r    <= cnt_nxt_s;
      rot_r    <= rot_nxt_s;
      result_r <= result_nxt_s;
      zero_r   <= zero_nxt_s;
      carry_r  <= carry_nxt_s;
      error_r  <= error_nxt_s;
      done_r   <= done_nxt_s;
      busy_r   <= (state_nxt_s == ST_EXEC);
    end
  end

  assign RESULT = result_r;
  assign BUSY   = busy_r;
  assign DONE   = done_r;
  assign ZERO   = zero_r;
  assign CARRY  = carry_r;
  assign ERROR  = error_r;

endmodule
